door_limit_model: RTL and testbench
===================================

# door_limit_model

Behavioural-synthesizable model of the door mechanism that sits on the far side of the up/down motor controller. It consumes the motor commands `up_M`/`dn_M`, tracks door position with a prescaled step counter, and generates the `up_max`/`dn_max` limit-switch signals that the controller consumes. It closes the loop for system-level simulation and FPGA demo, and flags illegal command combinations.

## Interface
- `TRAVEL`, default 16: number of position steps from fully down (0) to fully up (`TRAVEL`); must be ≥2.
- `STEP_DIV`, default 4: clock cycles of continuous motor command per position step; must be ≥1.
- `POS_W`, default 5: width of the position counter; must satisfy 2^POS_W > `TRAVEL`.
- `clk`  in  1  single system clock, rising-edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `up_M`  in  1  motor-up command from the controller.
- `dn_M`  in  1  motor-down command from the controller.
- `up_max`  out  1  upper limit switch.
- `dn_max`  out  1  lower limit switch.
- `pos`  out  POS_W  current position, 0..`TRAVEL`.
- `moving`  out  1  1 while a step is in progress (RISING/FALLING).
- `fault`  out  1  sticky illegal-command flag.

## Operation
- States, one-hot: BOTTOM, MID, TOP, RISING, FALLING, FAULT.
- Reset: state BOTTOM, `pos`=0, prescaler=0. Outputs: `dn_max`=1, `up_max`=0, `moving`=0, `fault`=0.
- All outputs are Moore: they are decoded from registered state and `pos` only.
  - `up_max` = (`pos`==`TRAVEL`) or FAULT.
  - `dn_max` = (`pos`==0) or FAULT.
  - `moving` = RISING or FALLING.
  - `fault` = FAULT.
- `up_M` & `dn_M` both 1, sampled in any state, goes to FAULT. FAULT is sticky until `rst`. In FAULT, `pos` is frozen. Both limits are driven to 1 so the controller parks in idle.
- BOTTOM/MID/TOP with `up_M`=1: go to RISING if `pos`<`TRAVEL`; otherwise stay in TOP.
- BOTTOM/MID/TOP with `dn_M`=1: go to FALLING if `pos`>0; otherwise stay in BOTTOM.
- RISING with `up_M`=1:
  - The prescaler increments each cycle.
  - When the prescaler is at `STEP_DIV`-1, `pos` increments and the prescaler clears.
  - If `pos` becomes `TRAVEL` on that edge, go to TOP.
- RISING with `up_M`=0: the prescaler clears, the partial step is discarded, `pos` holds.
  - With `dn_M`=1, go directly to FALLING (direction reversal).
  - Otherwise go to the rest state given by `pos` (0 gives BOTTOM, `TRAVEL` gives TOP, else MID).
- FALLING is symmetric to RISING: `pos` decrements, and reaching 0 goes to BOTTOM.
- Arithmetic: `pos` never wraps. Increment is blocked at `TRAVEL` and decrement at 0. The prescaler is $clog2(`STEP_DIV`) wide, minimum 1 bit.
- Reset mid-travel: async return to BOTTOM with `pos`=0 (the model is re-homed, not position-retentive).

## Timing
- The command is sampled on rising edge k. The state changes to RISING/FALLING at edge k, so `moving`=1 during cycle k+1.
- First `pos` change happens at edge k+`STEP_DIV`. Subsequent changes occur every `STEP_DIV` edges while the command is held.
- Full travel takes `TRAVEL`×`STEP_DIV` cycles from command sample to the limit asserting.
- The limit flag changes in the same cycle `pos` updates, because both are decoded from the same registers. The opposite limit deasserts with the first step, not on command acceptance.
- Command drop: `pos` is frozen from the sampling edge, and the prescaler is 0 the next cycle.
- Fault is detected on the sampling edge. `fault`, `up_max` and `dn_max` are all 1 from the next cycle.

## Structure
- Shared package `door_pkg`:
  - One-hot state localparams (3-bit controller encodings plus this block's 6-bit encoding).
  - Default `TRAVEL`/`STEP_DIV` constants, shared with the controller bench.
- Sub-module `step_prescaler`: counter with `en`/`clr` inputs and a `tick` output. It is instanced once; the FSM drives `en`=`moving`, and `clr` on any state exit.
- Three always blocks:
  - state/pos/prescaler registers with async `rst`;
  - next-state logic;
  - output decode.

## Test plan
All scenarios use `TRAVEL`=4, `STEP_DIV`=2.
- Reset with no command: `pos`=0, `dn_max`=1, `up_max`=0, `moving`=0, `fault`=0, stable for 20 cycles.
- Hold `up_M`=1 from BOTTOM:
  - `pos` steps 1,2,3,4 at edges 2,4,6,8 after sampling;
  - `up_max`=1 and `dn_max`=0 from the 8th cycle;
  - `moving`=0 thereafter even with `up_M` still 1.
- Pulse `up_M` for 3 cycles from BOTTOM: `pos`=1, state MID, both limits 0, prescaler 0. A following `dn_M` needs 2 full cycles to return `pos` to 0.
- Reversal: at `pos`=2 in RISING, switch `up_M`→0 and `dn_M`→1 in the same cycle. Result: FALLING with no idle cycle, and `pos`=1 two cycles later.
- Assert `up_M`=`dn_M`=1 at `pos`=2:
  - `fault`, `up_max` and `dn_max` are 1 from the next cycle;
  - `pos` stays 2 under any commands;
  - only `rst` clears it (to `pos`=0).
- Assert `rst` mid-travel at `pos`=3: all outputs take reset values asynchronously, before the next clock edge.
- Closed loop with the up/down controller: pulse `activate` at BOTTOM. Controller drives up for 8 cycles, then returns to idle one cycle after `up_max`.

Source files
------------

// File: rtl/door_pkg.sv
// Shared constants for the door mechanism model and the up/down controller it pairs with.
package door_pkg;

  // One-hot controller encodings, kept here so controller and door model agree.
  localparam logic [2:0] CTL_IDLE = 3'b001;
  localparam logic [2:0] CTL_UP   = 3'b010;
  localparam logic [2:0] CTL_DN   = 3'b100;

  localparam int DOOR_TRAVEL   = 16;
  localparam int DOOR_STEP_DIV = 4;

  typedef enum logic [5:0] {
    ST_BOTTOM  = 6'b000001,
    ST_MID     = 6'b000010,
    ST_TOP     = 6'b000100,
    ST_RISING  = 6'b001000,
    ST_FALLING = 6'b010000,
    ST_FAULT   = 6'b100000
  } door_state_e;

endpackage

// File: rtl/step_prescaler.sv
// Divides continuous motor-on time into position steps; tick marks the last cycle of a step.
module step_prescaler #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = en && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/door_limit_model.sv
// Door mechanism model: tracks position from motor commands and produces the limit switches.
module door_limit_model
  import door_pkg::*;
#(
  parameter int TRAVEL   = DOOR_TRAVEL,
  parameter int STEP_DIV = DOOR_STEP_DIV,
  parameter int POS_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_M,
  input  logic             dn_M,
  output logic             up_max,
  output logic             dn_max,
  output logic [POS_W-1:0] pos,
  output logic             moving,
  output logic             fault
);

  localparam logic [POS_W-1:0] POS_TOP = POS_W'(TRAVEL);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  door_state_e      r_state;
  door_state_e      w_state_nxt;
  door_state_e      w_rest;
  logic [POS_W-1:0] r_pos;
  logic [POS_W-1:0] w_pos_nxt;
  logic             w_tick;
  logic             w_clr;

  step_prescaler #(
    .STEP_DIV(STEP_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (moving),
    .clr  (w_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_BOTTOM;
      r_pos   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_rest      = (r_pos == '0) ? ST_BOTTOM : ((r_pos == POS_TOP) ? ST_TOP : ST_MID);
    if (up_M && dn_M) begin
      w_state_nxt = ST_FAULT;
    end else begin
      case (r_state)
        ST_BOTTOM, ST_MID, ST_TOP: begin
          if (up_M) begin
            w_state_nxt = (r_pos < POS_TOP) ? ST_RISING : ST_TOP;
          end else if (dn_M) begin
            w_state_nxt = (r_pos != '0) ? ST_FALLING : ST_BOTTOM;
          end
        end
        ST_RISING: begin
          if (up_M) begin
            if (w_tick && (r_pos < POS_TOP)) begin
              w_pos_nxt = r_pos + POS_ONE;
              if (w_pos_nxt == POS_TOP) w_state_nxt = ST_TOP;
            end
          end else if (dn_M) begin
            w_state_nxt = ST_FALLING;
          end else begin
            w_state_nxt = w_rest;
          end
        end
        ST_FALLING: begin
          if (dn_M) begin
            if (w_tick && (r_pos != '0)) begin
              w_pos_nxt = r_pos - POS_ONE;
              if (w_pos_nxt == '0) w_state_nxt = ST_BOTTOM;
            end
          end else if (up_M) begin
            w_state_nxt = ST_RISING;
          end else begin
            w_state_nxt = w_rest;
          end
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_FAULT;
        end
      endcase
    end
    // Any state change drops a partial step, including reversal and fault entry.
    w_clr = (w_state_nxt != r_state);
  end

  always_comb begin
    pos    = r_pos;
    fault  = (r_state == ST_FAULT);
    moving = (r_state == ST_RISING) || (r_state == ST_FALLING);
    up_max = (r_pos == POS_TOP) || fault;
    dn_max = (r_pos == '0) || fault;
  end

endmodule

// File: tb/tb_door_limit_model.sv
// Directed bench for door_limit_model with TRAVEL=4, STEP_DIV=2.
module tb_door_limit_model;

  logic       clk;
  logic       rst;
  logic       up_M;
  logic       dn_M;
  logic       up_max;
  logic       dn_max;
  logic [2:0] pos;
  logic       moving;
  logic       fault;

  int vectors;
  int miscompares;
  int n;

  door_limit_model #(
    .TRAVEL   (4),
    .STEP_DIV (2),
    .POS_W    (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .up_M   (up_M),
    .dn_M   (dn_M),
    .up_max (up_max),
    .dn_max (dn_max),
    .pos    (pos),
    .moving (moving),
    .fault  (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ev(input int p, input bit u, input bit d, input bit m, input bit f);
    logic [2:0] p3;
    p3 = 3'(p);
    return {p3, u, d, m, f};
  endfunction

  task automatic tick_n(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] expv);
    logic [6:0] obs;
    obs = {pos, up_max, dn_max, moving, fault};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed pos/up/dn/mv/flt=%b required=%b", tag, obs, expv);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; up_M = 1'b0; dn_M = 1'b0;
    tick_n(3);
    rst = 1'b0;
    chk("reset", ev(0, 0, 1, 0, 0));
    for (int i = 0; i < 20; i++) begin
      tick_n(1);
      chk($sformatf("idle_%0d", i), ev(0, 0, 1, 0, 0));
    end

    // Full rise: pos steps every 2 edges after the sampling edge.
    up_M = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      tick_n(1);
      chk($sformatf("rise_%0d", j),
          ev((j / 2 > 4) ? 4 : j / 2, j >= 8, j < 2, j < 8, 0));
    end
    up_M = 1'b0;
    tick_n(1);
    chk("top_rest", ev(4, 1, 0, 0, 0));

    dn_M = 1'b1;
    for (int j = 0; j <= 9; j++) begin
      tick_n(1);
      chk($sformatf("fall_%0d", j),
          ev(4 - ((j / 2 > 4) ? 4 : j / 2), j < 2, j >= 8, j < 8, 0));
    end
    dn_M = 1'b0;

    // Three-cycle pulse leaves the door one step up in MID.
    up_M = 1'b1;
    tick_n(2);
    chk("pulse_e1", ev(0, 0, 1, 1, 0));
    tick_n(1);
    chk("pulse_e2", ev(1, 0, 0, 1, 0));
    up_M = 1'b0;
    tick_n(1);
    chk("pulse_mid", ev(1, 0, 0, 0, 0));
    dn_M = 1'b1;
    tick_n(1);
    chk("pulse_dn0", ev(1, 0, 0, 1, 0));
    tick_n(1);
    chk("pulse_dn1", ev(1, 0, 0, 1, 0));
    tick_n(1);
    chk("pulse_dn2", ev(0, 0, 1, 0, 0));
    dn_M = 1'b0;

    // Reversal at pos=2.
    up_M = 1'b1;
    tick_n(5);
    chk("rev_pos2", ev(2, 0, 0, 1, 0));
    up_M = 1'b0; dn_M = 1'b1;
    tick_n(1);
    chk("rev_falling", ev(2, 0, 0, 1, 0));
    tick_n(1);
    chk("rev_hold", ev(2, 0, 0, 1, 0));
    tick_n(1);
    chk("rev_pos1", ev(1, 0, 0, 1, 0));
    tick_n(2);
    chk("rev_bottom", ev(0, 0, 1, 0, 0));
    dn_M = 1'b0;
    tick_n(1);
    chk("rev_rest", ev(0, 0, 1, 0, 0));

    // Illegal command at pos=2: sticky until reset.
    up_M = 1'b1;
    tick_n(5);
    chk("flt_pos2", ev(2, 0, 0, 1, 0));
    dn_M = 1'b1;
    tick_n(1);
    chk("flt_entry", ev(2, 1, 1, 0, 1));
    dn_M = 1'b0;
    tick_n(3);
    chk("flt_up", ev(2, 1, 1, 0, 1));
    up_M = 1'b0; dn_M = 1'b1;
    tick_n(3);
    chk("flt_dn", ev(2, 1, 1, 0, 1));
    dn_M = 1'b0;
    tick_n(2);
    chk("flt_none", ev(2, 1, 1, 0, 1));
    rst = 1'b1;
    #1;
    chk("flt_rst", ev(0, 0, 1, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick_n(1);
    chk("flt_cleared", ev(0, 0, 1, 0, 0));

    // Asynchronous reset mid-travel at pos=3.
    up_M = 1'b1;
    tick_n(7);
    chk("rstmid_pos3", ev(3, 0, 0, 1, 0));
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_async", ev(0, 0, 1, 0, 0));
    up_M = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick_n(1);
    chk("rstmid_after", ev(0, 0, 1, 0, 0));

    // Controller-style open: hold up until the limit, then release.
    up_M = 1'b1;
    tick_n(1);
    n = 0;
    while (!up_max && n < 50) begin
      tick_n(1);
      n++;
    end
    vectors++;
    assert (n === 8) else begin
      miscompares++;
      $error("FAIL loop_travel_cycles: observed %0d required %0d", n, 8);
    end
    up_M = 1'b0;
    tick_n(1);
    chk("loop_idle", ev(4, 1, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
